fpga_reg_bank: RTL and testbench

FPGA_REG_BANK -- requirements
Module: fpga_reg_bank

---
 rtl/fpga_reg_bank.sv | 135 +++++++++++++
 tb/tb_fpga_reg_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reg_bank.sv
// Parameterised register bank: working RW registers, live RO inputs, constant ID
// registers, and a shadow copy of the RW set updated only by transfer or soft reset.
module fpga_reg_bank #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned NUM_RW    = 4,
    parameter int unsigned NUM_RO    = 2,
    parameter int unsigned RW_BASE   = 'h10,
    parameter int unsigned RO_BASE   = 'h40,
    parameter logic [ADDR_SIZE-1:0] XFER_ADDR = '1,
    parameter logic [NUM_RW*DATA_SIZE-1:0] RW_DEFAULTS = '0,
    parameter int unsigned DEVICE_ID = 'h01,
    parameter int unsigned REVISION  = 'h00,
    parameter bit          AUTO_XFER = 1'b1
) (
    input  logic                        I_clk,
    input  logic                        I_rst_n,
    input  logic                        I_enable,
    input  logic                        I_wen,
    input  logic [ADDR_SIZE-1:0]        I_addr,
    input  logic [DATA_SIZE-1:0]        I_din,
    input  logic [NUM_RO*DATA_SIZE-1:0] I_ro,
    output logic [DATA_SIZE-1:0]        O_dout,
    output logic [NUM_RW*DATA_SIZE-1:0] O_regs,
    output logic                        O_xfer_pulse,
    output logic                        O_soft_reset
);

    localparam int unsigned RW_IDX_W = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam logic [ADDR_SIZE-1:0] CONFIG_ADDR   = ADDR_SIZE'(0);
    localparam logic [ADDR_SIZE-1:0] DEVICEID_ADDR = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] REVISION_ADDR = ADDR_SIZE'(2);

    logic [DATA_SIZE-1:0] rw_q [NUM_RW];
    logic                 soft_pending;
    logic                 xfer_pending;
    logic                 enable_q;

    logic                 wr_en;
    logic                 rw_hit;
    logic [RW_IDX_W-1:0]  rw_idx;
    logic                 ro_hit;
    logic [DATA_SIZE-1:0] ro_data;
    logic                 soft_req;
    logic                 xfer_req;
    logic [7:0]           config_rd;

    // Address decode for the RW and RO windows
    always_comb begin
        rw_hit  = 1'b0;
        rw_idx  = '0;
        ro_hit  = 1'b0;
        ro_data = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (I_addr == ADDR_SIZE'(RW_BASE + k)) begin
                rw_hit = 1'b1;
                rw_idx = RW_IDX_W'(k);
            end
        end
        for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (I_addr == ADDR_SIZE'(RO_BASE + j)) begin
                ro_hit  = 1'b1;
                ro_data = I_ro[j*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Request detection: soft reset, explicit transfer, and auto transfer on enable fall
    always_comb begin
        wr_en    = I_enable & I_wen;
        soft_req = wr_en && (I_addr == CONFIG_ADDR) && (I_din[5] || I_din[2]);
        xfer_req = (wr_en && (I_addr == XFER_ADDR) && I_din[0])
                 || (AUTO_XFER && enable_q && !I_enable);
        config_rd = 8'h18 | {2'b00, soft_pending, 2'b00, soft_pending, 2'b00};
    end

    // Register state: soft reset outranks transfer; transfer captures pre-write values
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int unsigned k = 0; k < NUM_RW; k++) begin
                rw_q[k] <= RW_DEFAULTS[k*DATA_SIZE +: DATA_SIZE];
            end
            O_regs       <= RW_DEFAULTS;
            soft_pending <= 1'b0;
            xfer_pending <= 1'b0;
            enable_q     <= 1'b0;
            O_xfer_pulse <= 1'b0;
            O_soft_reset <= 1'b0;
        end else begin
            enable_q     <= I_enable;
            O_soft_reset <= soft_pending;
            O_xfer_pulse <= xfer_pending & ~soft_pending;
            if (soft_pending) begin
                for (int unsigned k = 0; k < NUM_RW; k++) begin
                    rw_q[k] <= RW_DEFAULTS[k*DATA_SIZE +: DATA_SIZE];
                end
                O_regs       <= RW_DEFAULTS;
                soft_pending <= 1'b0;
                xfer_pending <= 1'b0;
            end else begin
                soft_pending <= soft_req;
                xfer_pending <= xfer_req;
                if (xfer_pending) begin
                    for (int unsigned k = 0; k < NUM_RW; k++) begin
                        O_regs[k*DATA_SIZE +: DATA_SIZE] <= rw_q[k];
                    end
                end
                if (wr_en && rw_hit) begin
                    rw_q[rw_idx] <= I_din;
                end
            end
        end
    end

    // Combinational read mux; zero whenever the access is not enabled
    always_comb begin
        O_dout = '0;
        if (I_enable) begin
            if (I_addr == CONFIG_ADDR) begin
                O_dout = DATA_SIZE'(config_rd);
            end else if (I_addr == DEVICEID_ADDR) begin
                O_dout = DATA_SIZE'(DEVICE_ID);
            end else if (I_addr == REVISION_ADDR) begin
                O_dout = DATA_SIZE'(REVISION);
            end else if (rw_hit) begin
                O_dout = rw_q[rw_idx];
            end else if (ro_hit) begin
                O_dout = ro_data;
            end else if (I_addr == XFER_ADDR) begin
                O_dout = DATA_SIZE'(xfer_pending);
            end
        end
    end

endmodule

// File: tb/tb_fpga_reg_bank.sv
// Bench for fpga_reg_bank: one instance with AUTO_XFER=0 and one with AUTO_XFER=1
// driven from the same stimulus, checked against a register-map model.
module tb_fpga_reg_bank;

    localparam logic [31:0] DEF = 32'h44332211;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, wen;
    logic [7:0]  addr, din;
    logic [15:0] ro;
    logic [7:0]  dout_a, dout_b;
    logic [31:0] regs_a, regs_b;
    logic        xp_a, xp_b, sr_a, sr_b;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = AUTO_XFER off, 1 = on
    int  wk [2][4];
    int  sh [2][4];
    bit  sp [2];
    bit  xpm[2];
    bit  enq[2];
    bit  xpl[2];
    bit  spl[2];

    logic [7:0] rd_a, rd_b, erd_a, erd_b;

    always #5 clk = ~clk;

    fpga_reg_bank #(.RW_DEFAULTS(DEF), .AUTO_XFER(1'b0)) dut_a (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en), .I_wen(wen), .I_addr(addr),
        .I_din(din), .I_ro(ro), .O_dout(dout_a), .O_regs(regs_a),
        .O_xfer_pulse(xp_a), .O_soft_reset(sr_a));

    fpga_reg_bank #(.RW_DEFAULTS(DEF), .AUTO_XFER(1'b1)) dut_b (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en), .I_wen(wen), .I_addr(addr),
        .I_din(din), .I_ro(ro), .O_dout(dout_b), .O_regs(regs_b),
        .O_xfer_pulse(xp_b), .O_soft_reset(sr_b));

    function automatic int def_slice(int k);
        logic [31:0] v;
        v = DEF >> (8 * k);
        return int'(v[7:0]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                wk[d][k] = def_slice(k);
                sh[d][k] = def_slice(k);
            end
            sp[d] = 0; xpm[d] = 0; enq[d] = 0; xpl[d] = 0; spl[d] = 0;
        end
    endtask

    task automatic model_step();
        bit wr, sreq, xreq;
        for (int d = 0; d < 2; d++) begin
            wr   = en && wen;
            sreq = wr && addr == 8'h00 && (din[5] || din[2]);
            xreq = (wr && addr == 8'hFF && din[0]) || (d == 1 && enq[d] && !en);
            spl[d] = sp[d];
            xpl[d] = xpm[d] && !sp[d];
            if (sp[d]) begin
                for (int k = 0; k < 4; k++) begin
                    wk[d][k] = def_slice(k);
                    sh[d][k] = def_slice(k);
                end
                sp[d]  = 0;
                xpm[d] = 0;
            end else begin
                if (xpm[d]) for (int k = 0; k < 4; k++) sh[d][k] = wk[d][k];
                xpm[d] = xreq;
                sp[d]  = sreq;
                if (wr && addr >= 8'h10 && addr <= 8'h13) wk[d][int'(addr) - 16] = int'(din);
            end
            enq[d] = en;
        end
    endtask

    function automatic logic [31:0] exp_regs(int d);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < 4; k++) v = v | (32'(sh[d][k] & 255) << (8 * k));
        return v;
    endfunction

    function automatic logic [7:0] exp_read(int d);
        if (!en) return 8'h00;
        if (addr == 8'h00) return sp[d] ? 8'h3C : 8'h18;
        if (addr == 8'h01) return 8'h01;
        if (addr == 8'h02) return 8'h00;
        if (addr >= 8'h10 && addr <= 8'h13) return 8'(wk[d][int'(addr) - 16]);
        if (addr == 8'h40) return ro[7:0];
        if (addr == 8'h41) return ro[15:8];
        if (addr == 8'hFF) return {7'b0, xpm[d]};
        return 8'h00;
    endfunction

    // One clock: apply inputs at negedge, capture reads, step model at posedge
    task automatic cycle(input bit e, input bit w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        en = e; wen = w; addr = a; din = d;
        #1;
        rd_a  = dout_a;
        rd_b  = dout_b;
        erd_a = exp_read(0);
        erd_b = exp_read(1);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; wen = 0; addr = 0; din = 0; ro = 16'hBEEF;
        model_reset();
        #12;
        total++; if (regs_a !== DEF) begin bad++; $display("FAIL reset_regs_a got=%h exp=%h", regs_a, DEF); end
        total++; if (regs_b !== DEF) begin bad++; $display("FAIL reset_regs_b got=%h exp=%h", regs_b, DEF); end
        total++; if ({xp_a, sr_a, xp_b, sr_b} !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {xp_a, sr_a, xp_b, sr_b}); end
        @(negedge clk); rst_n = 1'b1;
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (rd_a !== 8'h18) begin bad++; $display("FAIL rd_config got=%h exp=18", rd_a); end
        cycle(1, 0, 8'h01, 8'h00);
        total++; if (rd_a !== 8'h01) begin bad++; $display("FAIL rd_devid got=%h exp=01", rd_a); end
        cycle(1, 0, 8'h02, 8'h00);
        total++; if (rd_b !== 8'h00) begin bad++; $display("FAIL rd_rev got=%h exp=00", rd_b); end
        cycle(1, 0, 8'h10, 8'h00);
        total++; if (rd_a !== 8'h11) begin bad++; $display("FAIL rd_rw0_default got=%h exp=11", rd_a); end
    endtask

    task automatic test_xfer();
        cycle(1, 1, 8'h11, 8'hA5);
        total++; if (regs_a !== DEF) begin bad++; $display("FAIL xfer_no_leak got=%h exp=%h", regs_a, DEF); end
        cycle(1, 1, 8'hFF, 8'h01);
        total++; if (regs_a !== DEF || xp_a !== 1'b0) begin bad++; $display("FAIL xfer_req_edge got=%h/%b exp=%h/0", regs_a, xp_a, DEF); end
        cycle(1, 0, 8'hFF, 8'h00);
        total++; if (rd_a !== 8'h01) begin bad++; $display("FAIL xfer_pending_rd got=%h exp=01", rd_a); end
        total++; if (xp_a !== 1'b1 || regs_a[15:8] !== 8'hA5) begin bad++; $display("FAIL xfer_exec got=%b/%h exp=1/a5", xp_a, regs_a[15:8]); end
        total++; if (regs_b !== exp_regs(1)) begin bad++; $display("FAIL xfer_regs_b got=%h exp=%h", regs_b, exp_regs(1)); end
        cycle(1, 0, 8'h11, 8'h00);
        total++; if (xp_a !== 1'b0 || rd_a !== 8'hA5) begin bad++; $display("FAIL xfer_one_shot got=%b/%h exp=0/a5", xp_a, rd_a); end
    endtask

    task automatic test_auto();
        cycle(1, 1, 8'h10, 8'h3C);
        cycle(1, 0, 8'h10, 8'h00);
        total++; if (rd_b !== 8'h3C) begin bad++; $display("FAIL auto_working got=%h exp=3c", rd_b); end
        cycle(0, 0, 8'h00, 8'h00);
        total++; if (xp_b !== 1'b0 || regs_b[7:0] !== 8'h11) begin bad++; $display("FAIL auto_fall_edge got=%b/%h exp=0/11", xp_b, regs_b[7:0]); end
        cycle(0, 0, 8'h00, 8'h00);
        total++; if (xp_b !== 1'b1 || regs_b[7:0] !== 8'h3C) begin bad++; $display("FAIL auto_exec got=%b/%h exp=1/3c", xp_b, regs_b[7:0]); end
        total++; if (xp_a !== 1'b0 || regs_a[7:0] !== 8'h11) begin bad++; $display("FAIL auto_off got=%b/%h exp=0/11", xp_a, regs_a[7:0]); end
    endtask

    task automatic test_soft();
        cycle(1, 1, 8'h00, 8'h24);
        total++; if (sr_a !== 1'b0) begin bad++; $display("FAIL soft_early got=%b exp=0", sr_a); end
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (rd_a !== 8'h3C || rd_b !== 8'h3C) begin bad++; $display("FAIL soft_cfg_pending got=%h/%h exp=3c", rd_a, rd_b); end
        total++; if (sr_a !== 1'b1 || sr_b !== 1'b1) begin bad++; $display("FAIL soft_pulse got=%b%b exp=11", sr_a, sr_b); end
        total++; if (regs_a !== DEF || regs_b !== DEF) begin bad++; $display("FAIL soft_regs got=%h/%h exp=%h", regs_a, regs_b, DEF); end
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (rd_a !== 8'h18 || sr_a !== 1'b0) begin bad++; $display("FAIL soft_done got=%h/%b exp=18/0", rd_a, sr_a); end
        cycle(1, 0, 8'h10, 8'h00);
        total++; if (rd_a !== 8'h11 || rd_b !== 8'h11) begin bad++; $display("FAIL soft_working got=%h/%h exp=11", rd_a, rd_b); end
    endtask

    task automatic test_collision();
        cycle(1, 1, 8'h12, 8'h5A);
        cycle(1, 1, 8'hFF, 8'h01);
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (regs_b[23:16] !== 8'h5A) begin bad++; $display("FAIL coll_setup got=%h exp=5a", regs_b[23:16]); end
        cycle(1, 1, 8'h00, 8'h04);
        cycle(0, 0, 8'h00, 8'h00);
        total++; if (sr_b !== 1'b1 || xp_b !== 1'b0 || regs_b !== DEF) begin bad++; $display("FAIL coll_soft_wins got=%b/%b/%h exp=1/0/%h", sr_b, xp_b, regs_b, DEF); end
        cycle(0, 0, 8'h00, 8'h00);
        total++; if (xp_b !== 1'b0 || regs_b !== DEF) begin bad++; $display("FAIL coll_no_late_xfer got=%b/%h exp=0/%h", xp_b, regs_b, DEF); end
        cycle(1, 1, 8'h40, 8'h77);
        cycle(1, 1, 8'h30, 8'h77);
        cycle(1, 1, 8'h01, 8'h77);
        cycle(1, 0, 8'h30, 8'h00);
        total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL unmapped_rd got=%h exp=00", rd_a); end
        cycle(1, 0, 8'h40, 8'h00);
        total++; if (rd_a !== 8'hEF) begin bad++; $display("FAIL ro_rd got=%h exp=ef", rd_a); end
        cycle(1, 0, 8'h01, 8'h00);
        total++; if (rd_a !== 8'h01) begin bad++; $display("FAIL devid_ro got=%h exp=01", rd_a); end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 8'(16 + k), 8'h00);
            total++; if (rd_a !== 8'(def_slice(k))) begin bad++; $display("FAIL rw_untouched%0d got=%h exp=%h", k, rd_a, 8'(def_slice(k))); end
        end
        cycle(0, 0, 8'h10, 8'h00);
        total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL rd_disabled got=%h exp=00", rd_a); end
    endtask

    task automatic test_back_to_back();
        cycle(1, 1, 8'h12, 8'h55);
        cycle(1, 1, 8'hFF, 8'h01);
        cycle(1, 1, 8'h12, 8'h66);
        total++; if (xp_a !== 1'b1 || regs_a[23:16] !== 8'h55) begin bad++; $display("FAIL wr_during_xfer got=%b/%h exp=1/55", xp_a, regs_a[23:16]); end
        cycle(1, 0, 8'h12, 8'h00);
        total++; if (rd_a !== 8'h66 || xp_a !== 1'b0 || regs_a[23:16] !== 8'h55) begin bad++; $display("FAIL wr_after_xfer got=%h/%b/%h exp=66/0/55", rd_a, xp_a, regs_a[23:16]); end
        cycle(1, 1, 8'hFF, 8'h01);
        cycle(1, 1, 8'hFF, 8'h01);
        total++; if (xp_a !== 1'b1 || regs_a[23:16] !== 8'h66) begin bad++; $display("FAIL chain_first got=%b/%h exp=1/66", xp_a, regs_a[23:16]); end
        cycle(1, 0, 8'hFF, 8'h00);
        total++; if (rd_a !== 8'h01 || xp_a !== 1'b1) begin bad++; $display("FAIL chain_second got=%h/%b exp=01/1", rd_a, xp_a); end
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (xp_a !== 1'b0) begin bad++; $display("FAIL chain_end got=%b exp=0", xp_a); end
    endtask

    task automatic test_async();
        cycle(1, 1, 8'h13, 8'h99);
        cycle(1, 1, 8'hFF, 8'h01);
        cycle(1, 0, 8'h00, 8'h00);
        total++; if (regs_a[31:24] !== 8'h99) begin bad++; $display("FAIL async_setup got=%h exp=99", regs_a[31:24]); end
        cycle(1, 1, 8'h13, 8'h42);
        cycle(1, 1, 8'hFF, 8'h01);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (regs_a !== DEF || regs_b !== DEF) begin bad++; $display("FAIL async_immediate got=%h/%h exp=%h", regs_a, regs_b, DEF); end
        en = 0; wen = 0; addr = 0; din = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 8'h00, 8'h00);
        total++; if (xp_a !== 1'b0 || xp_b !== 1'b0 || regs_a !== DEF) begin bad++; $display("FAIL async_no_xfer got=%b%b/%h exp=00/%h", xp_a, xp_b, regs_a, DEF); end
        cycle(1, 0, 8'h13, 8'h00);
        total++; if (rd_a !== 8'h44) begin bad++; $display("FAIL async_working got=%h exp=44", rd_a); end
        cycle(1, 0, 8'hFF, 8'h00);
        total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL async_pending got=%h exp=00", rd_a); end
    endtask

    task automatic test_random();
        logic [7:0] amap [10];
        logic [7:0] a, d;
        amap = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h40, 8'h41, 8'hFF};
        for (int i = 0; i < 400; i++) begin
            ro = 16'($urandom);
            a  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : amap[$urandom_range(0, 9)];
            d  = 8'($urandom);
            if (a == 8'h00 && $urandom_range(0, 3) != 0) d = d & 8'hDB;
            cycle(($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1), a, d);
            total++; if (rd_a !== erd_a) begin bad++; $display("FAIL rnd_dout_a i=%0d got=%h exp=%h", i, rd_a, erd_a); end
            total++; if (rd_b !== erd_b) begin bad++; $display("FAIL rnd_dout_b i=%0d got=%h exp=%h", i, rd_b, erd_b); end
            total++; if (regs_a !== exp_regs(0)) begin bad++; $display("FAIL rnd_regs_a i=%0d got=%h exp=%h", i, regs_a, exp_regs(0)); end
            total++; if (regs_b !== exp_regs(1)) begin bad++; $display("FAIL rnd_regs_b i=%0d got=%h exp=%h", i, regs_b, exp_regs(1)); end
            total++; if ({xp_a, sr_a} !== {xpl[0], spl[0]}) begin bad++; $display("FAIL rnd_pulse_a i=%0d got=%b%b exp=%b%b", i, xp_a, sr_a, xpl[0], spl[0]); end
            total++; if ({xp_b, sr_b} !== {xpl[1], spl[1]}) begin bad++; $display("FAIL rnd_pulse_b i=%0d got=%b%b exp=%b%b", i, xp_b, sr_b, xpl[1], spl[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_xfer();
        test_auto();
        test_soft();
        test_collision();
        test_back_to_back();
        test_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
